// File: rtl/amber_pkg.sv
// Shared CSR address map, STATUS bit positions and the masked-merge helper
// used by the amber CSR file.
package amber_pkg;

  localparam int unsigned CSR_W = 24;

  localparam logic [11:0] CSR_STATUS     = 12'h000;
  localparam logic [11:0] CSR_CYCLE_LO   = 12'hC00;
  localparam logic [11:0] CSR_CYCLE_HI   = 12'hC01;
  localparam logic [11:0] CSR_INSTRET_LO = 12'hC02;
  localparam logic [11:0] CSR_INSTRET_HI = 12'hC03;

  localparam int unsigned ST_K  = 0;
  localparam int unsigned ST_PK = 1;

  // Bits with mask=1 take the new data, the rest keep the old value.
  function automatic logic [CSR_W-1:0] csr_merge(input logic [CSR_W-1:0] old,
                                                 input logic [CSR_W-1:0] data,
                                                 input logic [CSR_W-1:0] mask);
    return (data & mask) | (old & ~mask);
  endfunction

endpackage

// File: rtl/amber_csr_counter48.sv
// Double-word event counter with a per-read-port shadow of the high half,
// captured whenever that port reads the low half.
module amber_csr_counter48 #(
  parameter int unsigned HALF_W = 24,
  parameter int unsigned N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc_i,
  input  logic [N_RD-1:0]          lo_rd_i,
  output logic [HALF_W-1:0]        lo_o,
  output logic [HALF_W-1:0]        hi_o,
  output logic [N_RD*HALF_W-1:0]   shadow_o
);

  localparam int unsigned CNT_W = 2 * HALF_W;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_RD*HALF_W-1:0]   shadow_q, shadow_d;

  // Shadows latch the pre-increment high half, matching the low half read this cycle.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(inc_i);
    shadow_d = shadow_q;
    for (int unsigned p = 0; p < N_RD; p++) begin
      if (lo_rd_i[p]) shadow_d[p*HALF_W +: HALF_W] = cnt_q[CNT_W-1:HALF_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign lo_o     = cnt_q[HALF_W-1:0];
  assign hi_o     = cnt_q[CNT_W-1:HALF_W];
  assign shadow_o = shadow_q;

endmodule

// File: rtl/amber_csrfile.sv
// amber CSR file: STATUS mode stack, generic masked storage, cycle/instret
// counters with coherent hi/lo reads, and N_RD combinational read ports.
module amber_csrfile
  import amber_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned CSR_DEPTH = 1024,
  parameter int unsigned N_RD      = 2,
  parameter logic [ADDR_W-1:0] PRIV_TOP = ADDR_W'(12'h0FF)
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst_n,
  input  logic [N_RD*ADDR_W-1:0]   iw_rd_addr,
  output logic [N_RD*DATA_W-1:0]   ow_rd_data,
  output logic [N_RD-1:0]          ow_rd_illegal,
  input  logic                     iw_wr_en,
  input  logic [ADDR_W-1:0]        iw_wr_addr,
  input  logic [DATA_W-1:0]        iw_wr_data,
  input  logic [DATA_W-1:0]        iw_wr_mask,
  output logic                     ow_wr_illegal,
  input  logic                     iw_retire,
  input  logic                     iw_trap,
  input  logic                     iw_rti,
  output logic                     ow_kernel
);

  localparam int unsigned IDX_W = $clog2(CSR_DEPTH);

  logic                     k_q, k_d, pk_q, pk_d;
  logic                     wr_illegal_q;
  logic [DATA_W-1:0]        mem_q [CSR_DEPTH];
  logic [DATA_W-1:0]        status_word;
  logic [DATA_W-1:0]        wr_old, wr_new;
  logic                     wr_ok;
  logic [DATA_W-1:0]        cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic [N_RD*DATA_W-1:0]   cyc_sh, ins_sh;
  logic [N_RD-1:0]          cyc_lo_rd, ins_lo_rd;

  function automatic logic addr_is_cnt(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(CSR_CYCLE_LO)) && (a <= ADDR_W'(CSR_INSTRET_HI));
  endfunction

  function automatic logic addr_impl(input logic [ADDR_W-1:0] a);
    return (32'(a) < CSR_DEPTH) || addr_is_cnt(a);
  endfunction

  assign status_word = {{(DATA_W-2){1'b0}}, pk_q, k_q};

  // A write is accepted only to implemented, writable, privilege-permitted addresses.
  always_comb begin
    wr_ok  = iw_wr_en && addr_impl(iw_wr_addr) && !addr_is_cnt(iw_wr_addr) &&
             !((iw_wr_addr <= PRIV_TOP) && !k_q);
    wr_old = (iw_wr_addr == ADDR_W'(CSR_STATUS)) ? status_word
                                                 : mem_q[iw_wr_addr[IDX_W-1:0]];
    wr_new = csr_merge(wr_old, iw_wr_data, iw_wr_mask);
    if (iw_wr_addr == ADDR_W'(CSR_STATUS)) wr_new = {{(DATA_W-2){1'b0}}, wr_new[1:0]};
  end

  // Trap entry wins over return, which wins over a software STATUS write.
  always_comb begin
    k_d  = k_q;
    pk_d = pk_q;
    if (iw_trap) begin
      pk_d = k_q;
      k_d  = 1'b1;
    end else if (iw_rti) begin
      k_d = pk_q;
    end else if (wr_ok && (iw_wr_addr == ADDR_W'(CSR_STATUS))) begin
      k_d  = wr_new[ST_K];
      pk_d = wr_new[ST_PK];
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      k_q          <= 1'b1;
      pk_q         <= 1'b0;
      wr_illegal_q <= 1'b0;
      for (int unsigned i = 0; i < CSR_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      k_q          <= k_d;
      pk_q         <= pk_d;
      wr_illegal_q <= iw_wr_en && !wr_ok;
      if (wr_ok && (iw_wr_addr != ADDR_W'(CSR_STATUS)))
        mem_q[iw_wr_addr[IDX_W-1:0]] <= wr_new;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    logic              ill;

    assign a = iw_rd_addr[p*ADDR_W +: ADDR_W];

    // Same-cycle write to the same legal address is forwarded to the reader.
    always_comb begin
      v   = '0;
      ill = !addr_impl(a) || ((a <= PRIV_TOP) && !k_q);
      if (a == ADDR_W'(CSR_STATUS))          v = status_word;
      else if (a == ADDR_W'(CSR_CYCLE_LO))   v = cyc_lo;
      else if (a == ADDR_W'(CSR_CYCLE_HI))   v = cyc_sh[p*DATA_W +: DATA_W];
      else if (a == ADDR_W'(CSR_INSTRET_LO)) v = ins_lo;
      else if (a == ADDR_W'(CSR_INSTRET_HI)) v = ins_sh[p*DATA_W +: DATA_W];
      else if (32'(a) < CSR_DEPTH)           v = mem_q[a[IDX_W-1:0]];
      if (wr_ok && (iw_wr_addr == a)) v = wr_new;
      if (ill) v = '0;
    end

    assign ow_rd_data[p*DATA_W +: DATA_W] = v;
    assign ow_rd_illegal[p] = ill;
    assign cyc_lo_rd[p]     = !ill && (a == ADDR_W'(CSR_CYCLE_LO));
    assign ins_lo_rd[p]     = !ill && (a == ADDR_W'(CSR_INSTRET_LO));
  end

  amber_csr_counter48 #(.HALF_W(DATA_W), .N_RD(N_RD)) u_cycle (
    .clk      (iw_clk),
    .rst_n    (iw_rst_n),
    .inc_i    (1'b1),
    .lo_rd_i  (cyc_lo_rd),
    .lo_o     (cyc_lo),
    .hi_o     (cyc_hi),
    .shadow_o (cyc_sh)
  );

  amber_csr_counter48 #(.HALF_W(DATA_W), .N_RD(N_RD)) u_instret (
    .clk      (iw_clk),
    .rst_n    (iw_rst_n),
    .inc_i    (iw_retire),
    .lo_rd_i  (ins_lo_rd),
    .lo_o     (ins_lo),
    .hi_o     (ins_hi),
    .shadow_o (ins_sh)
  );

  assign ow_wr_illegal = wr_illegal_q;
  assign ow_kernel     = k_q;

endmodule
